mips_reg_dump: RTL and testbench
================================

Name: mips_reg_dump

Overview:
- Debug readback engine for pipe_MIPS32: the read-side counterpart to program/register loading.
- Once the processor is HALTED and a dump is requested, walks the register file Reg[0..NUM_REGS-1] through a read port.
- Streams each (index, value) pair out over a valid/ready interface to a host, debug UART or bench monitor.
- Sits beside the core, sharing its register-file read port while the pipeline is stopped.

Parameters:
- NUM_REGS, 32, number of registers dumped, indices 0..NUM_REGS-1; legal range 2..32.
- DATA_W, 32, register width.
- ADDR_W, 5, register index width; must satisfy 2^ADDR_W >= NUM_REGS.

Ports:
- clk1  in  1  single clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  dump request; sampled every cycle.
- halted  in  1  processor HALTED flag.
- rd_addr  out  ADDR_W  register-file read address.
- rd_data  in  DATA_W  register-file read data; combinational from rd_addr.
- out_valid  out  1  stream beat valid.
- out_ready  in  1  stream sink ready.
- out_index  out  ADDR_W  register index of the current beat.
- out_data  out  DATA_W  register value of the current beat.
- out_last  out  1  marks the beat for register NUM_REGS-1.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when the dump ends.
- aborted  out  1  sticky flag: the last dump was cut short by halted falling.

Behaviour:
- Reset, asynchronous:
  - State returns to IDLE.
  - All outputs go to 0, including rd_addr, out_index and out_data.
  - The index counter clears to 0.
  - Reset asserted mid-dump discards the dump; no done pulse is generated.
- IDLE:
  - start=1 and halted=1: go to READ, index=0, aborted cleared.
  - start=1 and halted=0: ignored; state stays IDLE.
- READ (1 cycle):
  - rd_addr = index.
  - At the clock edge: out_data<=rd_data, out_index<=index, out_last<=(index==NUM_REGS-1), out_valid<=1, go to SEND.
- SEND:
  - out_valid, out_index, out_data and out_last are held stable until out_valid&out_ready.
  - On that handshake: out_valid<=0.
    - If out_last=1, go to DONE.
    - Otherwise index<=index+1 and go to READ.
- DONE (1 cycle): done=1, then go to IDLE. busy drops in the cycle after DONE.
- Latency and throughput:
  - First beat is valid 2 cycles after start is sampled.
  - With out_ready held at 1, one beat every 2 cycles.
  - Full dump takes 2*NUM_REGS+1 cycles from start to the done pulse.
- rd_addr outside READ: holds its last value. It is never driven past NUM_REGS-1; the index never wraps.
- Abort (halted=0 while busy):
  - In READ: go to DONE, aborted<=1, no beat issued.
  - In SEND: the current beat stays valid until accepted, then go to DONE with aborted<=1, even if out_last=0.
  - Abort has priority over index advance.
- Simultaneous events:
  - start while busy (including in DONE) is ignored.
  - start and halted rising in the same cycle: accepted.
  - out_ready=1 with no valid beat has no effect.
- Arithmetic: the index counter is ADDR_W bits and compares against NUM_REGS-1; data passes through unmodified.

Test Plan:
- Register model holds the pipe_MIPS32 results R0=0, R1=10, R2=20, R3=25, R4=30, R5=55, Rk=k for k>=6. Halted=1, pulse start, out_ready=1 -> 32 beats (index 0..31) with those values; out_last only on index 31; done pulse at cycle 65 after start; aborted=0.
- Same setup with out_ready toggling 1,0,0,1 -> beats held stable while ready=0; same 32 values in order; done later; no beat duplicated or dropped.
- start with halted=0 -> busy stays 0, no beats, no done.
- halted drops while the beat for index 5 is in SEND with ready=0 -> beat 5 (value 55) held until ready; no beat 6; done pulse; aborted=1.
- start pulsed again during a dump -> ignored; after completion a new start clears aborted and restarts at index 0.
- reset asserted mid-dump at index 10 -> out_valid, busy and done go to 0 immediately (asynchronously); a following start dumps from index 0.

Source files
------------

// File: rtl/mips_reg_dump.sv
// Debug readback engine: once the core is halted, walks the register file and
// streams (index, value) beats over a valid/ready interface.
module mips_reg_dump #(
  parameter int NUM_REGS = 32,
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5
) (
  input  logic              clk1,
  input  logic              reset,
  input  logic              start,
  input  logic              halted,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_index,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic              aborted
);

  typedef enum logic [1:0] {IDLE, READ, SEND, DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] idx;
  logic              abort_pend;
  logic              accept;

  assign accept = out_valid & out_ready;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start && halted) state_nxt = READ;
      READ: state_nxt = halted ? SEND : DONE;
      SEND: begin
        if (accept)
          state_nxt = (out_last || abort_pend || !halted) ? DONE : READ;
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // halted falling during SEND is remembered so the abort survives until the
  // pending beat is finally accepted, even if halted comes back meanwhile.
  always_ff @(posedge clk1 or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      idx        <= '0;
      abort_pend <= 1'b0;
      aborted    <= 1'b0;
      out_valid  <= 1'b0;
      out_index  <= '0;
      out_data   <= '0;
      out_last   <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start && halted) begin
            idx        <= '0;
            aborted    <= 1'b0;
            abort_pend <= 1'b0;
          end
        end
        READ: begin
          if (halted) begin
            out_data  <= rd_data;
            out_index <= idx;
            out_last  <= (idx == LAST_IDX);
            out_valid <= 1'b1;
          end else begin
            aborted <= 1'b1;
          end
        end
        SEND: begin
          if (!halted) abort_pend <= 1'b1;
          if (accept) begin
            out_valid <= 1'b0;
            if (abort_pend || !halted) aborted <= 1'b1;
            else if (!out_last) idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // idx only moves on the way into READ, so it doubles as the held read address.
  assign rd_addr = idx;
  assign busy    = (state != IDLE);
  assign done    = (state == DONE);

endmodule

// File: tb/tb_mips_reg_dump.sv
// Self-checking bench for mips_reg_dump: a register-file array feeds the read
// port and every streamed beat is compared against the expected dump sequence.
module tb_mips_reg_dump;
  localparam int N  = 32;
  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk1 = 1'b0;
  logic          reset;
  logic          start;
  logic          halted;
  logic          out_ready;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          out_valid;
  logic [AW-1:0] out_index;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          busy;
  logic          done;
  logic          aborted;

  logic [DW-1:0] regs [N];
  int asserts = 0;
  int fails   = 0;
  int dc;

  always #5 clk1 = ~clk1;

  assign rd_data = regs[rd_addr];

  mips_reg_dump #(.NUM_REGS(N), .DATA_W(DW), .ADDR_W(AW)) dut (
    .clk1(clk1), .reset(reset), .start(start), .halted(halted),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_index(out_index),
    .out_data(out_data), .out_last(out_last),
    .busy(busy), .done(done), .aborted(aborted)
  );

  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  task automatic applyStimulus(input logic s, input logic h, input logic r);
    start     = s;
    halted    = h;
    out_ready = r;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    asserts++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // mode 0: ready always 1; mode 1: ready pattern 1,0,0,1; mode 2: random ready.
  // abortIdx >= 0 drops halted when that beat first appears (with ready held low).
  // midStart > 0 pulses start at that cycle of the dump.
  task automatic runDump(input int mode, input int abortIdx, input int midStart,
                         output int doneCyc);
    int            nextIdx, cyc, expCount, abortWait;
    logic          held, accepted, r, h, s;
    logic [AW-1:0] hIdx;
    logic [DW-1:0] hData;
    logic          hLast;
    bit            fin;
    expCount  = (abortIdx >= 0) ? abortIdx + 1 : N;
    nextIdx   = 0;
    held      = 1'b0;
    accepted  = 1'b0;
    doneCyc   = -1;
    h         = 1'b1;
    abortWait = 0;
    hIdx      = '0;
    hData     = '0;
    hLast     = 1'b0;
    fin       = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b0);
    tick();
    cyc = 1;
    checkOutput("busy_after_start", busy, 1);
    checkOutput("aborted_cleared", aborted, 0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    while (!fin && cyc < 600) begin
      if (accepted) checkOutput("valid_drop_after_accept", out_valid, 0);
      if (done) begin
        doneCyc = cyc;
        fin     = 1'b1;
      end else begin
        if (held) begin
          checkOutput("hold_valid", out_valid, 1);
          checkOutput("hold_index", out_index, hIdx);
          checkOutput("hold_data", out_data, hData);
          checkOutput("hold_last", out_last, hLast);
        end else if (out_valid) begin
          checkOutput("beat_in_range", nextIdx < expCount, 1);
          if (nextIdx < expCount) begin
            checkOutput("beat_index", out_index, nextIdx);
            checkOutput("beat_data", out_data, regs[nextIdx]);
            checkOutput("beat_last", out_last, nextIdx == N - 1);
            checkOutput("rd_addr_hold", rd_addr, nextIdx);
          end
          hIdx  = out_index;
          hData = out_data;
          hLast = out_last;
        end
        case (mode)
          0:       r = 1'b1;
          1:       r = (cyc % 4 == 0) || (cyc % 4 == 3);
          default: r = 1'($urandom_range(0, 1));
        endcase
        if (abortIdx >= 0 && out_valid && h && out_index == AW'(abortIdx)) begin
          h         = 1'b0;
          abortWait = 3;
        end
        if (abortWait > 0) begin
          r = 1'b0;
          abortWait--;
        end
        s = (midStart > 0) && (cyc == midStart);
        applyStimulus(s, h, r);
        accepted = out_valid && r;
        held     = out_valid && !r;
        if (accepted) nextIdx++;
        tick();
        cyc++;
      end
    end
    checkOutput("done_seen", fin, 1);
    checkOutput("beat_count", nextIdx, expCount);
    checkOutput("busy_in_done", busy, 1);
    applyStimulus(1'b0, 1'b1, 1'b0);
    tick();
    checkOutput("done_pulse_width", done, 0);
    checkOutput("busy_after_done", busy, 0);
    checkOutput("aborted_flag", aborted, abortIdx >= 0);
  endtask

  initial begin
    int waitCnt;
    for (int k = 0; k < N; k++) regs[k] = DW'(k);
    regs[0] = 0;  regs[1] = 10; regs[2] = 20;
    regs[3] = 25; regs[4] = 30; regs[5] = 55;
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0);
    #12;
    checkOutput("reset_out_valid", out_valid, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_aborted", aborted, 0);
    checkOutput("reset_rd_addr", rd_addr, 0);
    checkOutput("reset_out_index", out_index, 0);
    checkOutput("reset_out_data", out_data, 0);
    checkOutput("reset_out_last", out_last, 0);
    @(negedge clk1);
    reset = 1'b0;
    tick();

    $display("[TB] full dump, ready held high");
    runDump(0, -1, 0, dc);
    checkOutput("done_cycle_full", dc, 2 * N + 1);

    $display("[TB] full dump, ready toggling");
    runDump(1, -1, 0, dc);
    checkOutput("done_cycle_later", dc > 2 * N + 1, 1);

    $display("[TB] start while not halted");
    applyStimulus(1'b1, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 5; k++) begin
      checkOutput("nohalt_busy", busy, 0);
      checkOutput("nohalt_valid", out_valid, 0);
      checkOutput("nohalt_done", done, 0);
      tick();
    end

    $display("[TB] abort at beat 5");
    runDump(0, 5, 0, dc);

    $display("[TB] start pulsed mid-dump");
    runDump(0, -1, 9, dc);
    checkOutput("done_cycle_midstart", dc, 2 * N + 1);

    $display("[TB] random register contents, random ready");
    for (int k = 0; k < N; k++) regs[k] = $urandom;
    runDump(2, -1, 0, dc);

    $display("[TB] reset mid-dump at index 10");
    applyStimulus(1'b1, 1'b1, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b1);
    waitCnt = 0;
    while (!(out_valid && out_index == AW'(10)) && waitCnt < 100) begin
      tick();
      waitCnt++;
    end
    checkOutput("reach_index10", waitCnt < 100, 1);
    checkOutput("busy_before_reset", busy, 1);
    #2 reset = 1'b1;
    #1;
    checkOutput("async_reset_valid", out_valid, 0);
    checkOutput("async_reset_busy", busy, 0);
    checkOutput("async_reset_done", done, 0);
    checkOutput("async_reset_index", out_index, 0);
    @(negedge clk1);
    reset = 1'b0;
    applyStimulus(1'b0, 1'b1, 1'b0);
    tick();
    checkOutput("no_done_after_reset", done, 0);
    runDump(0, -1, 0, dc);
    checkOutput("done_cycle_after_reset", dc, 2 * N + 1);

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
